// File: rtl/hazard_class_pipe.sv
// hazard_class_pipe: decodes the D-stage instruction into hazard classes,
// carries class flags and destination registers down E->M->W, and raises
// load-use / branch-operand stalls with a saturating stall-cycle counter.
module hazard_class_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      InstrD,
    output logic [4:0]       RsD,
    output logic [4:0]       RtD,
    output logic [4:0]       RsE,
    output logic [4:0]       RtE,
    output logic [4:0]       RdE,
    output logic [4:0]       WriteRegE,
    output logic [4:0]       WriteRegM,
    output logic [4:0]       WriteRegW,
    output logic             b_typeD,
    output logic             jrD,
    output logic             cal_rE,
    output logic             cal_iE,
    output logic             ldE,
    output logic             stE,
    output logic             cal_rM,
    output logic             cal_iM,
    output logic             ldM,
    output logic             stM,
    output logic             cal_rW,
    output logic             cal_iW,
    output logic             ldW,
    output logic             stW,
    output logic             jalM,
    output logic             jalW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt
);

    // Per-stage class record; an all-zero value is a bubble.
    typedef struct packed {
        logic       cal_r;
        logic       cal_i;
        logic       ld;
        logic       st;
        logic       jal;
        logic [4:0] wr;
    } cls_t;

    logic [5:0] op, funct;
    logic [4:0] rd_d;
    logic       cal_r_d, cal_i_d, ld_d, st_d, b_type_d, jr_d, jal_d;
    logic       use_rs, use_rt, stall;
    logic       shamt_unused;
    cls_t       dec_d;
    cls_t       e_d, e_q, m_d, m_q, w_d, w_q;
    logic [4:0] rs_e_d, rs_e_q, rt_e_d, rt_e_q, rd_e_d, rd_e_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign op           = InstrD[31:26];
    assign funct        = InstrD[5:0];
    assign RsD          = InstrD[25:21];
    assign RtD          = InstrD[20:16];
    assign rd_d         = InstrD[15:11];
    // shamt never affects hazard classification
    assign shamt_unused = ^InstrD[10:6];

    // D-stage decode: class flags, destination and operand usage.
    // j (op 02) has no register operands or destination, so it stays class-less.
    always_comb begin
        cal_r_d  = 1'b0;
        jr_d     = 1'b0;
        if (op == 6'h00) begin
            cal_r_d = (funct == 6'h21) || (funct == 6'h23) || (funct == 6'h24) ||
                      (funct == 6'h25) || (funct == 6'h2A);
            jr_d    = (funct == 6'h08);
        end
        cal_i_d  = (op == 6'h09) || (op == 6'h0D) || (op == 6'h0F);
        ld_d     = (op == 6'h23);
        st_d     = (op == 6'h2B);
        b_type_d = (op == 6'h04) || (op == 6'h05);
        jal_d    = (op == 6'h03);
        use_rs   = cal_r_d | cal_i_d | ld_d | st_d | b_type_d | jr_d;
        // store data is forwarded at M, so rt of a store never stalls
        use_rt   = cal_r_d | b_type_d;
        dec_d        = '0;
        dec_d.cal_r  = cal_r_d;
        dec_d.cal_i  = cal_i_d;
        dec_d.ld     = ld_d;
        dec_d.st     = st_d;
        dec_d.jal    = jal_d;
        if (cal_r_d)              dec_d.wr = rd_d;
        else if (cal_i_d || ld_d) dec_d.wr = RtD;
        else if (jal_d)           dec_d.wr = 5'd31;
    end

    // Stall detect: load-use (A), branch on ALU result in E (B), branch on load in M (C).
    always_comb begin
        logic a, b, c, br;
        br = b_type_d | jr_d;
        a  = e_q.ld && (e_q.wr != 5'd0) &&
             ((use_rs && RsD == e_q.wr) || (use_rt && RtD == e_q.wr));
        b  = br && (e_q.cal_r || e_q.cal_i) && (e_q.wr != 5'd0) &&
             ((RsD == e_q.wr) || (b_type_d && RtD == e_q.wr));
        c  = br && m_q.ld && (m_q.wr != 5'd0) &&
             ((RsD == m_q.wr) || (b_type_d && RtD == m_q.wr));
        stall = a | b | c;
    end

    // Next-state: bubble into E on stall, M/W always advance, counter saturates.
    always_comb begin
        e_d    = stall ? '0 : dec_d;
        rs_e_d = stall ? 5'd0 : RsD;
        rt_e_d = stall ? 5'd0 : RtD;
        rd_e_d = stall ? 5'd0 : rd_d;
        m_d    = e_q;
        w_d    = m_q;
        cnt_d  = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Pipeline registers and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            rs_e_q <= 5'd0;
            rt_e_q <= 5'd0;
            rd_e_q <= 5'd0;
            cnt_q  <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            rs_e_q <= rs_e_d;
            rt_e_q <= rt_e_d;
            rd_e_q <= rd_e_d;
            cnt_q  <= cnt_d;
        end
    end

    assign b_typeD   = b_type_d;
    assign jrD       = jr_d;
    assign RsE       = rs_e_q;
    assign RtE       = rt_e_q;
    assign RdE       = rd_e_q;
    assign WriteRegE = e_q.wr;
    assign WriteRegM = m_q.wr;
    assign WriteRegW = w_q.wr;
    assign cal_rE    = e_q.cal_r;
    assign cal_iE    = e_q.cal_i;
    assign ldE       = e_q.ld;
    assign stE       = e_q.st;
    assign cal_rM    = m_q.cal_r;
    assign cal_iM    = m_q.cal_i;
    assign ldM       = m_q.ld;
    assign stM       = m_q.st;
    assign jalM      = m_q.jal;
    assign cal_rW    = w_q.cal_r;
    assign cal_iW    = w_q.cal_i;
    assign ldW       = w_q.ld;
    assign stW       = w_q.st;
    assign jalW      = w_q.jal;
    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushE    = stall;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_class_pipe.sv
// tb_hazard_class_pipe: directed vectors with hand-computed expectations for
// the hazard classifier; a second instance with CNT_W=2 checks saturation.
module tb_hazard_class_pipe;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] LW8     = 32'h8C08_0000; // lw    $8,0($0)
    localparam logic [31:0] LW0     = 32'h8C00_0000; // lw    $0,0($0)
    localparam logic [31:0] ADDU988 = 32'h0108_4821; // addu  $9,$8,$8
    localparam logic [31:0] BEQ80   = 32'h1100_0000; // beq   $8,$0
    localparam logic [31:0] BEQ08   = 32'h1008_0000; // beq   $0,$8
    localparam logic [31:0] ADDIU8  = 32'h2408_0001; // addiu $8,$0,1
    localparam logic [31:0] JAL     = 32'h0C00_0000; // jal   0

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] InstrD;

    logic [4:0]  RsD, RtD, RsE, RtE, RdE, WriteRegE, WriteRegM, WriteRegW;
    logic        b_typeD, jrD, cal_rE, cal_iE, ldE, stE, cal_rM, cal_iM, ldM, stM;
    logic        cal_rW, cal_iW, ldW, stW, jalM, jalW, StallF, StallD, FlushE;
    logic [31:0] stall_cnt;

    logic [4:0]  s_RsD, s_RtD, s_RsE, s_RtE, s_RdE, s_WriteRegE, s_WriteRegM, s_WriteRegW;
    logic        s_b_typeD, s_jrD, s_cal_rE, s_cal_iE, s_ldE, s_stE, s_cal_rM, s_cal_iM;
    logic        s_ldM, s_stM, s_cal_rW, s_cal_iW, s_ldW, s_stW, s_jalM, s_jalW;
    logic        s_StallF, s_StallD, s_FlushE;
    logic [1:0]  s_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int ns, tot;

    always #5 clk = ~clk;

    hazard_class_pipe #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .b_typeD(b_typeD), .jrD(jrD),
        .cal_rE(cal_rE), .cal_iE(cal_iE), .ldE(ldE), .stE(stE),
        .cal_rM(cal_rM), .cal_iM(cal_iM), .ldM(ldM), .stM(stM),
        .cal_rW(cal_rW), .cal_iW(cal_iW), .ldW(ldW), .stW(stW),
        .jalM(jalM), .jalW(jalW),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .stall_cnt(stall_cnt)
    );

    hazard_class_pipe #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD),
        .RsD(s_RsD), .RtD(s_RtD), .RsE(s_RsE), .RtE(s_RtE), .RdE(s_RdE),
        .WriteRegE(s_WriteRegE), .WriteRegM(s_WriteRegM), .WriteRegW(s_WriteRegW),
        .b_typeD(s_b_typeD), .jrD(s_jrD),
        .cal_rE(s_cal_rE), .cal_iE(s_cal_iE), .ldE(s_ldE), .stE(s_stE),
        .cal_rM(s_cal_rM), .cal_iM(s_cal_iM), .ldM(s_ldM), .stM(s_stM),
        .cal_rW(s_cal_rW), .cal_iW(s_cal_iW), .ldW(s_ldW), .stW(s_stW),
        .jalM(s_jalM), .jalW(s_jalW),
        .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an instruction in D, holding it while StallD is high (bounded),
    // then let it advance into E; D returns to nop afterwards.
    task automatic issue(input logic [31:0] ins, output int stalls);
        stalls = 0;
        InstrD = ins;
        #1;
        while (StallD && stalls < 4) begin
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        InstrD = NOP;
    endtask

    task automatic do_reset();
        InstrD = NOP;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        InstrD = NOP;
        #2;
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_stall", {29'd0, StallF, StallD, FlushE}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // load-use: lw $8 then addu $9,$8,$8
        issue(LW8, ns);
        chk("t2_ldE", {27'd0, ldE}, 1);
        chk("t2_wrE", WriteRegE, 8);
        InstrD = ADDU988; #1;
        chk("t2_stall_comb", {29'd0, StallF, StallD, FlushE}, 3'b111);
        issue(ADDU988, ns);
        chk("t2_nstall", ns, 1);
        chk("t2_cnt", stall_cnt, 1);
        chk("t2_E_rs_rt_rd", {17'd0, RsE, RtE, RdE}, {17'd0, 5'd8, 5'd8, 5'd9});
        chk("t2_E_calr_wr", {26'd0, cal_rE, WriteRegE}, {26'd0, 1'b1, 5'd9});
        chk("t2_M_bubble", {26'd0, ldM, WriteRegM}, 0);
        chk("t2_W_lw", {26'd0, ldW, WriteRegW}, {26'd0, 1'b1, 5'd8});

        // reset asserted mid-stall clears state and stall outputs at once
        issue(LW8, ns);
        InstrD = ADDU988; #1;
        chk("t1_pre_stall", {31'd0, StallD}, 1);
        rst_n = 1'b0; #1;
        chk("t1_stall", {29'd0, StallF, StallD, FlushE}, 0);
        chk("t1_cnt", stall_cnt, 0);
        chk("t1_E", {11'd0, ldE, cal_rE, cal_iE, stE, WriteRegE, RsE, RtE, RdE}, 0);
        chk("t1_MW", {20'd0, ldM, ldW, cal_rW, jalW, WriteRegM, WriteRegW}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        InstrD = NOP;

        // lw $8 then beq $8,$0: two stalls (A then C)
        do_reset();
        issue(LW8, ns);
        issue(BEQ80, ns);
        chk("t3_nstall", ns, 2);
        chk("t3_cnt", stall_cnt, 2);
        chk("t3_E_beq", {22'd0, RsE, RtE}, {22'd0, 5'd8, 5'd0});
        chk("t3_E_flags", {26'd0, ldE, WriteRegE}, 0);

        // addiu $8 then beq $0,$8: one stall (B)
        do_reset();
        issue(ADDIU8, ns);
        chk("t4_E_cali", {26'd0, cal_iE, WriteRegE}, {26'd0, 1'b1, 5'd8});
        issue(BEQ08, ns);
        chk("t4_nstall_b", ns, 1);
        chk("t4_cnt_b", stall_cnt, 1);

        // lw $0 then beq $0,$8: destination $0 never stalls
        do_reset();
        issue(LW0, ns);
        issue(BEQ08, ns);
        chk("t4_nstall_r0", ns, 0);
        chk("t4_cnt_r0", stall_cnt, 0);

        // jal travels to M then W with destination 31
        do_reset();
        tot = 0;
        issue(JAL, ns); tot += ns;
        issue(NOP, ns); tot += ns;
        chk("t5_M", {26'd0, jalM, WriteRegM}, {26'd0, 1'b1, 5'd31});
        issue(NOP, ns); tot += ns;
        chk("t5_W", {26'd0, jalW, WriteRegW}, {26'd0, 1'b1, 5'd31});
        chk("t5_nstall", tot, 0);

        // five load-use stalls: wide counter reaches 5, 2-bit counter sticks at 3
        do_reset();
        tot = 0;
        for (int i = 0; i < 5; i++) begin
            issue(LW8, ns); tot += ns;
            issue(ADDU988, ns); tot += ns;
            if (i == 1) chk("t6_small_mid", {30'd0, s_stall_cnt}, 2);
        end
        chk("t6_nstall", tot, 5);
        chk("t6_cnt_wide", stall_cnt, 5);
        chk("t6_cnt_sat", {30'd0, s_stall_cnt}, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
